// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared opcodes, state encoding, ALU class and mux-select codes
package multicycle_control_unit_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_EXEC_I    = 4'd4,
        S_EXEC_LUI  = 4'd5,
        S_ALU_WB    = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JAL       = 4'd12,
        S_JALR      = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_e;

    // Class codes understood by ALU_Control
    typedef enum logic [2:0] {
        ALU_OP_R    = 3'b000,
        ALU_OP_I    = 3'b001,
        ALU_OP_LUI  = 3'b010,
        ALU_OP_SW   = 3'b011,
        ALU_OP_B    = 3'b100,
        ALU_OP_JALR = 3'b101,
        ALU_OP_LW   = 3'b110,
        ALU_OP_ADD  = 3'b111
    } alu_op_e;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;

    localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
    localparam logic [1:0] RESULT_MEM     = 2'b01;
    localparam logic [1:0] RESULT_PC      = 2'b10;

    localparam logic [1:0] SRC_A_PC       = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC    = 2'b01;
    localparam logic [1:0] SRC_A_RS1      = 2'b10;

    localparam logic [1:0] SRC_B_RS2      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// rtl/multicycle_control_unit_opcode_classifier.sv - opcode to post-DECODE state and illegal flag
module multicycle_control_unit_opcode_classifier
    import multicycle_control_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [3:0] next_state_o,
    output logic       is_store_o,
    output logic       illegal_o
);

    always_comb begin
        next_state_o = S_ILLEGAL;
        is_store_o   = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OPC_R:      next_state_o = S_EXEC_R;
            OPC_I:      next_state_o = S_EXEC_I;
            OPC_LUI:    next_state_o = S_EXEC_LUI;
            OPC_LOAD:   next_state_o = S_MEM_ADDR;
            OPC_STORE: begin
                next_state_o = S_MEM_ADDR;
                is_store_o   = 1'b1;
            end
            OPC_BRANCH: next_state_o = S_BRANCH;
            OPC_JAL:    next_state_o = S_JAL;
            OPC_JALR:   next_state_o = S_JALR;
            default:    illegal_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I main FSM with retired-instruction counter
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode_i,
    input  logic                     mem_ready_i,
    input  logic                     branch_cond_i,
    output logic                     pc_write_o,
    output logic [1:0]               pc_src_o,
    output logic                     ir_write_o,
    output logic                     adr_src_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic                     reg_write_o,
    output logic [1:0]               result_src_o,
    output logic [1:0]               alu_src_a_o,
    output logic [1:0]               alu_src_b_o,
    output logic [2:0]               alu_op_o,
    output logic                     illegal_o,
    output logic                     retire_o,
    output logic [INSTRET_WIDTH-1:0] instret_o,
    output logic [3:0]               state_o
);

    state_e                   state_q, state_d;
    logic                     is_store_q, is_store_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic [3:0] cls_next_state;
    logic       cls_is_store;
    logic       cls_illegal;

    multicycle_control_unit_opcode_classifier u_classifier (
        .opcode_i     (opcode_i),
        .next_state_o (cls_next_state),
        .is_store_o   (cls_is_store),
        .illegal_o    (cls_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            is_store_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        ir_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = RESULT_ALUOUT;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        alu_op_o     = ALU_OP_R;
        illegal_o    = 1'b0;
        retire_o     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_OP_ADD;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed here into ALUOut
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_OP_ADD;
                is_store_d  = cls_is_store;
                state_d     = cls_illegal ? S_ILLEGAL : state_e'(cls_next_state);
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_OP_R;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_OP_I;
                state_d     = S_ALU_WB;
            end
            S_EXEC_LUI: begin
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_OP_LUI;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = is_store_q ? ALU_OP_SW : ALU_OP_LW;
                state_d     = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                adr_src_o  = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                result_src_o = RESULT_MEM;
                retire_o     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                alu_op_o    = ALU_OP_B;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_write_o  = branch_cond_i;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_op_o     = ALU_OP_ADD;
                pc_write_o   = 1'b1;
                pc_src_o     = PC_SRC_ALUOUT;
                reg_write_o  = 1'b1;
                result_src_o = RESULT_PC;
                retire_o     = 1'b1;
                state_d      = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_IMM;
                alu_op_o     = ALU_OP_JALR;
                pc_write_o   = 1'b1;
                reg_write_o  = 1'b1;
                result_src_o = RESULT_PC;
                retire_o     = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_o = 1'b1;
                if (!ILLEGAL_HALT) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase

        instret_d = instret_q + INSTRET_WIDTH'(retire_o);
    end

    assign instret_o = instret_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] op;
        logic       illegal;
        logic       retire;
    } out_t;

    typedef struct {
        out_t        outs;
        logic [31:0] instret;
    } sb_t;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LUI = 7'b0110111;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_B   = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_JR  = 7'b1100111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic mem_ready = 1'b0;
    logic branch_cond = 1'b0;

    logic pc_write1, ir_write1, adr_src1, mem_read1, mem_write1, reg_write1, illegal1, retire1;
    logic [1:0] pc_src1, result_src1, src_a1, src_b1;
    logic [2:0] op1;
    logic [31:0] instret1;
    logic [3:0] state1;

    logic pc_write2, ir_write2, adr_src2, mem_read2, mem_write2, reg_write2, illegal2, retire2;
    logic [1:0] pc_src2, result_src2, src_a2, src_b2;
    logic [2:0] op2;
    logic [3:0] instret2;
    logic [3:0] state2;

    int checks = 0;
    int failures = 0;
    logic sel = 1'b0;
    logic exp_store = 1'b0;
    logic exp_halt = 1'b1;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.INSTRET_WIDTH(32), .ILLEGAL_HALT(1'b1)) u_dut_halt (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .branch_cond_i(branch_cond), .pc_write_o(pc_write1), .pc_src_o(pc_src1),
        .ir_write_o(ir_write1), .adr_src_o(adr_src1), .mem_read_o(mem_read1),
        .mem_write_o(mem_write1), .reg_write_o(reg_write1), .result_src_o(result_src1),
        .alu_src_a_o(src_a1), .alu_src_b_o(src_b1), .alu_op_o(op1), .illegal_o(illegal1),
        .retire_o(retire1), .instret_o(instret1), .state_o(state1)
    );

    multicycle_control_unit #(.INSTRET_WIDTH(4), .ILLEGAL_HALT(1'b0)) u_dut_nop (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .branch_cond_i(branch_cond), .pc_write_o(pc_write2), .pc_src_o(pc_src2),
        .ir_write_o(ir_write2), .adr_src_o(adr_src2), .mem_read_o(mem_read2),
        .mem_write_o(mem_write2), .reg_write_o(reg_write2), .result_src_o(result_src2),
        .alu_src_a_o(src_a2), .alu_src_b_o(src_b2), .alu_op_o(op2), .illegal_o(illegal2),
        .retire_o(retire2), .instret_o(instret2), .state_o(state2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic out_t exp_out(input state_e st, input logic rdy, input logic cond);
        out_t e;
        e = '0;
        e.state = st;
        case (st)
            S_FETCH: begin
                e.mem_read = 1'b1; e.src_b = 2'b01; e.op = 3'b111;
                if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            end
            S_DECODE:   begin e.src_a = 2'b01; e.src_b = 2'b10; e.op = 3'b111; end
            S_EXEC_R:   begin e.src_a = 2'b10; e.op = 3'b000; end
            S_EXEC_I:   begin e.src_a = 2'b10; e.src_b = 2'b10; e.op = 3'b001; end
            S_EXEC_LUI: begin e.src_b = 2'b10; e.op = 3'b010; end
            S_ALU_WB:   begin e.reg_write = 1'b1; e.retire = 1'b1; end
            S_MEM_ADDR: begin
                e.src_a = 2'b10; e.src_b = 2'b10; e.op = exp_store ? 3'b011 : 3'b110;
            end
            S_MEM_READ:  begin e.mem_read = 1'b1; e.adr_src = 1'b1; end
            S_MEM_WB:    begin e.reg_write = 1'b1; e.result_src = 2'b01; e.retire = 1'b1; end
            S_MEM_WRITE: begin e.mem_write = 1'b1; e.adr_src = 1'b1; e.retire = rdy; end
            S_BRANCH: begin
                e.src_a = 2'b10; e.op = 3'b100; e.pc_src = 2'b01;
                e.pc_write = cond; e.retire = 1'b1;
            end
            S_JAL: begin
                e.op = 3'b111; e.pc_write = 1'b1; e.pc_src = 2'b01;
                e.reg_write = 1'b1; e.result_src = 2'b10; e.retire = 1'b1;
            end
            S_JALR: begin
                e.src_a = 2'b10; e.src_b = 2'b10; e.op = 3'b101; e.pc_write = 1'b1;
                e.reg_write = 1'b1; e.result_src = 2'b10; e.retire = 1'b1;
            end
            S_ILLEGAL: begin e.illegal = 1'b1; e.retire = !exp_halt; end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a falling edge: drive, queue expectation, compare, advance one cycle
    task automatic cyc(input state_e st, input logic [6:0] opc, input logic rdy,
                       input logic cond, input int ei);
        sb_t  e;
        out_t got;
        logic [31:0] got_i;
        opcode = opc;
        mem_ready = rdy;
        branch_cond = cond;
        sb_q.push_back('{outs: exp_out(st, rdy, cond),
                         instret: sel ? (32'(ei) & 32'hF) : 32'(ei)});
        #1;
        if (sel) begin
            got = {state2, pc_write2, pc_src2, ir_write2, adr_src2, mem_read2, mem_write2,
                   reg_write2, result_src2, src_a2, src_b2, op2, illegal2, retire2};
            got_i = {28'd0, instret2};
        end else begin
            got = {state1, pc_write1, pc_src1, ir_write1, adr_src1, mem_read1, mem_write1,
                   reg_write1, result_src1, src_a1, src_b1, op1, illegal1, retire1};
            got_i = instret1;
        end
        e = sb_q.pop_front();
        check_eq($sformatf("outs_%s", st.name()), {9'd0, got}, {9'd0, e.outs});
        check_eq($sformatf("instret_%s", st.name()), got_i, e.instret);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] add_word;
        add_word = 32'h00B50533;
        @(negedge clk);
        do_reset();

        cyc(S_RESET, T_R, 1'b0, 1'b0, 0);
        cyc(S_FETCH, add_word[6:0], 1'b0, 1'b0, 0);
        cyc(S_FETCH, add_word[6:0], 1'b1, 1'b0, 0);
        cyc(S_DECODE, add_word[6:0], 1'b1, 1'b0, 0);
        cyc(S_EXEC_R, add_word[6:0], 1'b1, 1'b0, 0);
        cyc(S_ALU_WB, add_word[6:0], 1'b0, 1'b0, 0);

        exp_store = 1'b0;
        cyc(S_FETCH, T_LD, 1'b1, 1'b0, 1);
        cyc(S_DECODE, T_LD, 1'b0, 1'b0, 1);
        cyc(S_MEM_ADDR, T_ST, 1'b1, 1'b0, 1);
        for (int i = 0; i < 3; i++) cyc(S_MEM_READ, T_LD, 1'b0, 1'b0, 1);
        cyc(S_MEM_READ, T_LD, 1'b1, 1'b0, 1);
        cyc(S_MEM_WB, T_LD, 1'b0, 1'b0, 1);

        cyc(S_FETCH, T_B, 1'b1, 1'b0, 2);
        cyc(S_DECODE, T_B, 1'b0, 1'b0, 2);
        cyc(S_BRANCH, T_B, 1'b1, 1'b0, 2);
        cyc(S_FETCH, T_B, 1'b1, 1'b1, 3);
        cyc(S_DECODE, T_B, 1'b0, 1'b1, 3);
        cyc(S_BRANCH, T_B, 1'b0, 1'b1, 3);

        cyc(S_FETCH, T_JR, 1'b1, 1'b0, 4);
        cyc(S_DECODE, T_JR, 1'b0, 1'b0, 4);
        cyc(S_JALR, T_JR, 1'b0, 1'b0, 4);

        cyc(S_FETCH, T_ST, 1'b1, 1'b0, 5);
        cyc(S_DECODE, T_ST, 1'b1, 1'b0, 5);
        exp_store = 1'b1;
        cyc(S_MEM_ADDR, T_LD, 1'b0, 1'b0, 5);
        cyc(S_MEM_WRITE, T_ST, 1'b0, 1'b0, 5);
        cyc(S_MEM_WRITE, T_ST, 1'b1, 1'b0, 5);

        cyc(S_FETCH, T_JAL, 1'b1, 1'b0, 6);
        cyc(S_DECODE, T_JAL, 1'b0, 1'b0, 6);
        cyc(S_JAL, T_JAL, 1'b0, 1'b0, 6);
        cyc(S_FETCH, T_I, 1'b1, 1'b0, 7);
        cyc(S_DECODE, T_I, 1'b0, 1'b0, 7);
        cyc(S_EXEC_I, T_I, 1'b0, 1'b0, 7);
        cyc(S_ALU_WB, T_I, 1'b0, 1'b0, 7);
        cyc(S_FETCH, T_LUI, 1'b1, 1'b0, 8);
        cyc(S_DECODE, T_LUI, 1'b0, 1'b0, 8);
        cyc(S_EXEC_LUI, T_LUI, 1'b0, 1'b0, 8);
        cyc(S_ALU_WB, T_LUI, 1'b0, 1'b0, 8);

        cyc(S_FETCH, T_ST, 1'b1, 1'b0, 9);
        cyc(S_DECODE, T_ST, 1'b0, 1'b0, 9);
        cyc(S_MEM_ADDR, T_ST, 1'b0, 1'b0, 9);
        cyc(S_MEM_WRITE, T_ST, 1'b0, 1'b0, 9);
        do_reset();
        cyc(S_RESET, T_ST, 1'b0, 1'b0, 0);

        exp_halt = 1'b1;
        cyc(S_FETCH, T_BAD, 1'b1, 1'b0, 0);
        cyc(S_DECODE, T_BAD, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) cyc(S_ILLEGAL, T_R, 1'(i), 1'b0, 0);
        do_reset();
        cyc(S_RESET, T_R, 1'b0, 1'b0, 0);

        sel = 1'b1;
        exp_halt = 1'b0;
        do_reset();
        cyc(S_RESET, T_BAD, 1'b0, 1'b0, 0);
        cyc(S_FETCH, T_BAD, 1'b1, 1'b0, 0);
        cyc(S_DECODE, T_BAD, 1'b0, 1'b0, 0);
        cyc(S_ILLEGAL, T_BAD, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 15; k++) begin
            cyc(S_FETCH, T_JAL, 1'b1, 1'b0, k);
            cyc(S_DECODE, T_JAL, 1'b0, 1'b0, k);
            cyc(S_JAL, T_JAL, 1'b0, 1'b0, k);
        end
        cyc(S_FETCH, T_JAL, 1'b0, 1'b0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
